// File: rtl/axi_rt_pkg.sv
// rtl/axi_rt_pkg.sv - shared types and helpers for the AXI RT response regulator
package axi_rt_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    DEPLETED = 2'd2
  } rt_resp_state_e;

  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned SatWidth     = 64;

  typedef struct packed {
    logic [AxiAddrWidth-1:0] aw_addr;
    logic                    aw_valid;
    logic [AxiDataWidth-1:0] w_data;
    logic                    w_last;
    logic                    w_valid;
    logic                    b_ready;
    logic [AxiAddrWidth-1:0] ar_addr;
    logic                    ar_valid;
    logic                    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic                    aw_ready;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    ar_ready;
    logic [AxiDataWidth-1:0] r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
  } axi_resp_t;

  function automatic logic [SatWidth-1:0] sat_sub(input logic [SatWidth-1:0] a,
                                                  input logic [SatWidth-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/axi_rt_resp_counter.sv
// rtl/axi_rt_resp_counter.sv - per-channel period/budget counter, state machine and throttle flag
module axi_rt_resp_counter
  import axi_rt_pkg::*;
#(
  parameter int unsigned PeriodWidth = 32,
  parameter int unsigned BudgetWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   abort_i,
  input  logic                   handshake_i,
  input  logic [BudgetWidth-1:0] cost_i,
  input  logic [BudgetWidth-1:0] budget_i,
  input  logic [PeriodWidth-1:0] period_i,
  output logic [BudgetWidth-1:0] budget_left_o,
  output logic [PeriodWidth-1:0] period_left_o,
  output logic                   throttled_o
);

  localparam logic [PeriodWidth-1:0] PeriodOne = PeriodWidth'(1);

  rt_resp_state_e         state_q, state_d;
  logic [BudgetWidth-1:0] budget_q, budget_d, budget_base;
  logic [PeriodWidth-1:0] period_q, period_d, period_load;
  logic                   refill;

  always_comb begin
    state_d     = state_q;
    budget_d    = budget_q;
    period_d    = period_q;
    refill      = 1'b0;
    budget_base = budget_q;
    period_load = (period_i == '0) ? PeriodOne : period_i;
    if (!enable_i) begin
      state_d  = IDLE;
      budget_d = '0;
      period_d = '0;
    end else begin
      // Leaving IDLE, abort and the last period cycle all load fresh limits;
      // a handshake in that same cycle is charged against the new budget.
      refill      = abort_i || (state_q == IDLE) || (period_q == PeriodOne);
      budget_base = refill ? budget_i : budget_q;
      budget_d    = BudgetWidth'(sat_sub(SatWidth'(budget_base),
                                         handshake_i ? SatWidth'(cost_i) : '0));
      period_d    = refill ? period_load : (period_q - PeriodOne);
      state_d     = (budget_d < cost_i) ? DEPLETED : ACTIVE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      budget_q <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      budget_q <= budget_d;
      period_q <= period_d;
    end
  end

  assign budget_left_o = budget_q;
  assign period_left_o = period_q;
  assign throttled_o   = (state_q == DEPLETED);

endmodule

// File: rtl/axi_rt_resp_regulator.sv
// rtl/axi_rt_resp_regulator.sv - response-side (R/B) budget regulator for one AXI subordinate port
// Optional stall statistics outputs: define AXI_RT_RESP_REGULATOR_STATS_EN.
module axi_rt_resp_regulator
  import axi_rt_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned PeriodWidth = 32,
  parameter int unsigned BudgetWidth = 32,
  parameter type         axi_req_t   = axi_rt_pkg::axi_req_t,
  parameter type         axi_resp_t  = axi_rt_pkg::axi_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  axi_req_t               slv_req_i,
  output axi_resp_t              slv_resp_o,
  output axi_req_t               mst_req_o,
  input  axi_resp_t              mst_resp_i,
  input  logic                   enable_i,
  input  logic                   abort_i,
  input  logic [BudgetWidth-1:0] r_budget_i,
  input  logic [PeriodWidth-1:0] r_period_i,
  input  logic [BudgetWidth-1:0] b_budget_i,
  input  logic [PeriodWidth-1:0] b_period_i,
  output logic [BudgetWidth-1:0] r_budget_left_o,
  output logic [PeriodWidth-1:0] r_period_left_o,
  output logic [BudgetWidth-1:0] b_budget_left_o,
  output logic [PeriodWidth-1:0] b_period_left_o,
  output logic                   r_throttled_o,
  output logic                   b_throttled_o
`ifdef AXI_RT_RESP_REGULATOR_STATS_EN
  ,
  output logic [31:0]            r_stall_cycles_o,
  output logic [31:0]            b_stall_cycles_o
`endif
);

  localparam logic [BudgetWidth-1:0] RCost = BudgetWidth'(DataWidth / 8);
  localparam logic [BudgetWidth-1:0] BCost = BudgetWidth'(1);

  logic r_hs, b_hs;

  // Everything passes through; only the R/B valid/ready pairs are masked.
  always_comb begin
    mst_req_o          = slv_req_i;
    slv_resp_o         = mst_resp_i;
    mst_req_o.r_ready  = slv_req_i.r_ready  & ~r_throttled_o;
    slv_resp_o.r_valid = mst_resp_i.r_valid & ~r_throttled_o;
    mst_req_o.b_ready  = slv_req_i.b_ready  & ~b_throttled_o;
    slv_resp_o.b_valid = mst_resp_i.b_valid & ~b_throttled_o;
  end

  assign r_hs = slv_resp_o.r_valid & slv_req_i.r_ready;
  assign b_hs = slv_resp_o.b_valid & slv_req_i.b_ready;

  axi_rt_resp_counter #(
    .PeriodWidth(PeriodWidth),
    .BudgetWidth(BudgetWidth)
  ) i_r_counter (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .abort_i      (abort_i),
    .handshake_i  (r_hs),
    .cost_i       (RCost),
    .budget_i     (r_budget_i),
    .period_i     (r_period_i),
    .budget_left_o(r_budget_left_o),
    .period_left_o(r_period_left_o),
    .throttled_o  (r_throttled_o)
  );

  axi_rt_resp_counter #(
    .PeriodWidth(PeriodWidth),
    .BudgetWidth(BudgetWidth)
  ) i_b_counter (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .abort_i      (abort_i),
    .handshake_i  (b_hs),
    .cost_i       (BCost),
    .budget_i     (b_budget_i),
    .period_i     (b_period_i),
    .budget_left_o(b_budget_left_o),
    .period_left_o(b_period_left_o),
    .throttled_o  (b_throttled_o)
  );

`ifdef AXI_RT_RESP_REGULATOR_STATS_EN
  // Stall cycles: throttled while the subordinate is holding a response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || abort_i) begin
      r_stall_cycles_o <= '0;
      b_stall_cycles_o <= '0;
    end else begin
      if (r_throttled_o && mst_resp_i.r_valid && (r_stall_cycles_o != '1))
        r_stall_cycles_o <= r_stall_cycles_o + 32'd1;
      if (b_throttled_o && mst_resp_i.b_valid && (b_stall_cycles_o != '1))
        b_stall_cycles_o <= b_stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule
